// File: rtl/hw_ptr_wrbck_pkg.sv
// Shared constants, FSM/beat encodings and byte-swap helper for the hardware pointer writeback engine.
package hw_ptr_wrbck_pkg;

    localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'b10_00000;
    localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'b11_00000;
    localparam logic [9:0] WRBCK_LEN_DW      = 10'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_H0,
        ST_H1,
        ST_D
    } state_e;

    typedef enum logic [1:0] {
        BEAT_HDR0 = 2'd0,
        BEAT_HDR1 = 2'd1,
        BEAT_DATA = 2'd2
    } beat_e;

    // Pointer payload goes out little-endian within each DW.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/hw_ptr_wrbck_fmt.sv
// Combinational TRN beat formatter for the 2-DW pointer MemWr TLP (3DW or 4DW header chosen by address).
module hw_ptr_wrbck_fmt
    import hw_ptr_wrbck_pkg::*;
#(
    parameter logic [7:0] TAG = 8'h00
) (
    input  logic [63:2] addr_s,
    input  logic [63:0] ptr_s,
    input  logic [15:0] cpl_id,
    input  logic [1:0]  beat_idx,
    output logic [63:0] td,
    output logic [7:0]  trem_n
);

    logic        is64;
    logic [6:0]  fmt_type;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] addr_lo;

    always_comb begin
        is64     = |addr_s[63:32];
        fmt_type = is64 ? MEM_WR64_FMT_TYPE : MEM_WR32_FMT_TYPE;
        dw0      = {1'b0, fmt_type, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, WRBCK_LEN_DW};
        dw1      = {cpl_id, TAG, 4'hF, 4'hF};
        d0       = bswap32(ptr_s[31:0]);
        d1       = bswap32(ptr_s[63:32]);
        addr_lo  = {addr_s[31:2], 2'b00};
        td       = 64'h0;
        trem_n   = 8'hFF;
        case (beat_idx)
            BEAT_HDR0: begin
                td     = {dw0, dw1};
                trem_n = 8'h00;
            end
            BEAT_HDR1: begin
                td     = is64 ? {addr_s[63:32], addr_lo} : {addr_lo, d0};
                trem_n = 8'h00;
            end
            BEAT_DATA: begin
                // 3DW header leaves only D1 for the last beat, in the upper DW.
                td     = is64 ? {d0, d1} : {d1, 32'h0};
                trem_n = is64 ? 8'h00 : 8'h0F;
            end
            default: begin
                td     = 64'h0;
                trem_n = 8'hFF;
            end
        endcase
    end

endmodule

// File: rtl/hw_ptr_wrbck.sv
// Posts the 64-bit hardware ring pointer to host memory as a MemWr TLP whenever it changes.
// Optional HW_WRBCK_HOLDOFF_EN enforces HOLDOFF_CYCLES between TLP starts to coalesce bursts.
module hw_ptr_wrbck
    import hw_ptr_wrbck_pkg::*;
#(
    parameter int         HOLDOFF_CYCLES = 64,
    parameter logic [7:0] TAG            = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrbck_en,
    input  logic [63:0] host_addr,
    input  logic [63:0] hw_ptr,
    input  logic [15:0] cfg_completer_id,
    output logic        tx_req,
    input  logic        tx_gnt,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [3:0]  trn_tbuf_av,
    output logic        wrbck_done
);

    // TRN handshake: a beat transfers on a clock edge where src_rdy_n and dst_rdy_n are both low;
    // until then the beat (td/trem_n/sof_n/eof_n) is held unchanged.

    state_e      state_q, state_d;
    logic [63:0] ptr_s_q, ptr_s_d;
    logic [63:2] addr_s_q, addr_s_d;
    logic [63:0] last_q, last_d;
    logic        tx_req_q, tx_req_d;
    logic [63:0] td_q, td_d;
    logic [7:0]  trem_q, trem_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        src_q, src_d;
    logic        done_q, done_d;

    logic        beat_acc;
    logic        launch;
    logic        hold_ok;
    logic [1:0]  fmt_idx;
    logic [63:0] fmt_td;
    logic [7:0]  fmt_trem;
    logic        unused_ok;

    assign unused_ok = ^{host_addr[1:0], trn_tbuf_av[3:2], trn_tbuf_av[0]};
    assign beat_acc  = !src_q && !trn_tdst_rdy_n;
    assign launch    = (state_q == ST_IDLE) && wrbck_en && (hw_ptr != last_q) && hold_ok;

`ifdef HW_WRBCK_HOLDOFF_EN
    localparam int              HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        if (launch) hold_d = HOLD_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end

    assign hold_ok = (hold_q == '0);
`else
    assign hold_ok = 1'b1;
`endif

    always_comb begin
        case (state_q)
            ST_H0:   fmt_idx = BEAT_HDR1;
            ST_H1:   fmt_idx = BEAT_DATA;
            default: fmt_idx = BEAT_HDR0;
        endcase
    end

    hw_ptr_wrbck_fmt #(.TAG(TAG)) u_fmt (
        .addr_s   (addr_s_q),
        .ptr_s    (ptr_s_q),
        .cpl_id   (cfg_completer_id),
        .beat_idx (fmt_idx),
        .td       (fmt_td),
        .trem_n   (fmt_trem)
    );

    always_comb begin
        state_d  = state_q;
        ptr_s_d  = ptr_s_q;
        addr_s_d = addr_s_q;
        last_d   = last_q;
        tx_req_d = tx_req_q;
        td_d     = td_q;
        trem_d   = trem_q;
        sof_d    = sof_q;
        eof_d    = eof_q;
        src_d    = src_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    ptr_s_d  = hw_ptr;
                    addr_s_d = host_addr[63:2];
                    tx_req_d = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (tx_gnt && trn_tbuf_av[1]) begin
                    td_d    = fmt_td;
                    trem_d  = fmt_trem;
                    sof_d   = 1'b0;
                    src_d   = 1'b0;
                    state_d = ST_H0;
                end
            end
            ST_H0: begin
                if (beat_acc) begin
                    td_d    = fmt_td;
                    trem_d  = fmt_trem;
                    sof_d   = 1'b1;
                    state_d = ST_H1;
                end
            end
            ST_H1: begin
                if (beat_acc) begin
                    td_d    = fmt_td;
                    trem_d  = fmt_trem;
                    eof_d   = 1'b0;
                    state_d = ST_D;
                end
            end
            ST_D: begin
                if (beat_acc) begin
                    td_d     = 64'h0;
                    trem_d   = 8'hFF;
                    eof_d    = 1'b1;
                    src_d    = 1'b1;
                    tx_req_d = 1'b0;
                    last_d   = ptr_s_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_s_q  <= 64'h0;
            addr_s_q <= '0;
            last_q   <= 64'h0;
            tx_req_q <= 1'b0;
            td_q     <= 64'h0;
            trem_q   <= 8'hFF;
            sof_q    <= 1'b1;
            eof_q    <= 1'b1;
            src_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_s_q  <= ptr_s_d;
            addr_s_q <= addr_s_d;
            last_q   <= last_d;
            tx_req_q <= tx_req_d;
            td_q     <= td_d;
            trem_q   <= trem_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            src_q    <= src_d;
            done_q   <= done_d;
        end
    end

    assign tx_req         = tx_req_q;
    assign trn_td         = td_q;
    assign trn_trem_n     = trem_q;
    assign trn_tsof_n     = sof_q;
    assign trn_teof_n     = eof_q;
    assign trn_tsrc_rdy_n = src_q;
    assign wrbck_done     = done_q;

endmodule

// File: tb/tb_hw_ptr_wrbck.sv
// Directed bench for hw_ptr_wrbck: TLP beat model with expected queue, handshake/hold monitor, literal pins.
module tb_hw_ptr_wrbck;

    localparam int         HOLD   = 16;
    localparam logic [15:0] CPL_ID = 16'h0100;
    localparam logic [7:0]  TAG    = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrbck_en = 1'b1;
    logic [63:0] host_addr = 64'h0;
    logic [63:0] hw_ptr = 64'h0;
    logic [15:0] cfg_completer_id = CPL_ID;
    logic        tx_req;
    logic        tx_gnt = 1'b1;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n = 1'b0;
    logic [3:0]  trn_tbuf_av = 4'hF;
    logic        wrbck_done;

    always #5 clk = ~clk;

    hw_ptr_wrbck #(.HOLDOFF_CYCLES(HOLD), .TAG(TAG)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wrbck_en         (wrbck_en),
        .host_addr        (host_addr),
        .hw_ptr           (hw_ptr),
        .cfg_completer_id (cfg_completer_id),
        .tx_req           (tx_req),
        .tx_gnt           (tx_gnt),
        .trn_td           (trn_td),
        .trn_trem_n       (trn_trem_n),
        .trn_tsof_n       (trn_tsof_n),
        .trn_teof_n       (trn_teof_n),
        .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n   (trn_tdst_rdy_n),
        .trn_tbuf_av      (trn_tbuf_av),
        .wrbck_done       (wrbck_done)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int req_rise = 0;
    int src_low_cnt = 0;
    int last_rise_cyc = 0;
    int cap_idx = 0;
    bit sb_off = 1'b0;
    bit hold_chk = 1'b0;
    bit prev_pend = 1'b0;
    bit prev_req = 1'b0;
    logic [73:0] prev_beat;
    logic [73:0] mon_beat;
    logic [73:0] exp_beat;
    logic [73:0] cap [3];
    logic [73:0] exp_q [$];

    task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bsw(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = x[8*(3-i) +: 8];
        return r;
    endfunction

    function automatic logic [73:0] mk_beat(input logic [63:0] td, input logic [7:0] trem,
                                            input logic sof, input logic eof);
        return {td, trem, sof, eof};
    endfunction

    // Expected beats of one pointer writeback, derived from the TLP layout rules.
    task automatic push_tlp(input logic [63:0] addr, input logic [63:0] ptr);
        logic        is64;
        logic [31:0] dw0, dw1, a_lo;
        is64 = (addr[63:32] != 32'h0);
        dw0  = is64 ? 32'h6000_0002 : 32'h4000_0002;
        dw1  = {CPL_ID, TAG, 8'hFF};
        a_lo = {addr[31:2], 2'b00};
        exp_q.push_back(mk_beat({dw0, dw1}, 8'h00, 1'b0, 1'b1));
        if (is64) begin
            exp_q.push_back(mk_beat({addr[63:32], a_lo}, 8'h00, 1'b1, 1'b1));
            exp_q.push_back(mk_beat({bsw(ptr[31:0]), bsw(ptr[63:32])}, 8'h00, 1'b1, 1'b0));
        end else begin
            exp_q.push_back(mk_beat({a_lo, bsw(ptr[31:0])}, 8'h00, 1'b1, 1'b1));
            exp_q.push_back(mk_beat({bsw(ptr[63:32]), 32'h0}, 8'h0F, 1'b1, 1'b0));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
            prev_req  = 1'b0;
        end else begin
            cyc++;
            mon_beat = mk_beat(trn_td, trn_trem_n, trn_tsof_n, trn_teof_n);
            if (tx_req && !prev_req) begin
                req_rise++;
                if (hold_chk) chk("holdoff_spacing", 74'(cyc - last_rise_cyc >= HOLD), 74'(1));
                last_rise_cyc = cyc;
            end
            prev_req = tx_req;
            if (wrbck_done) done_cnt++;
            if (!trn_tsrc_rdy_n) src_low_cnt++;
            if (prev_pend && !trn_tsrc_rdy_n) chk("beat_hold", mon_beat, prev_beat);
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                if (!trn_tsof_n) cap_idx = 0;
                if (cap_idx < 3) cap[cap_idx] = mon_beat;
                cap_idx++;
                if (!sb_off) begin
                    chk("beat_expected", 74'(exp_q.size() != 0), 74'(1));
                    if (exp_q.size() != 0) begin
                        exp_beat = exp_q.pop_front();
                        chk("beat_data", mon_beat, exp_beat);
                    end
                end
            end
            prev_pend = !trn_tsrc_rdy_n && trn_tdst_rdy_n;
            prev_beat = mon_beat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n);
        int target;
        target = done_cnt + n;
        for (int i = 0; i < 300 && done_cnt < target; i++) tick();
        chk("done_timeout", 74'(done_cnt >= target), 74'(1));
    endtask

    task automatic wait_beat0();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (!trn_tsrc_rdy_n && !trn_tsof_n) found = 1'b1;
        end
        chk("beat0_timeout", 74'(found), 74'(1));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_req"}, 74'(tx_req), 74'(0));
        chk({tag, "_sof_n"}, 74'(trn_tsof_n), 74'(1));
        chk({tag, "_eof_n"}, 74'(trn_teof_n), 74'(1));
        chk({tag, "_src_rdy_n"}, 74'(trn_tsrc_rdy_n), 74'(1));
        chk({tag, "_trem_n"}, 74'(trn_trem_n), 74'(8'hFF));
        chk({tag, "_td"}, 74'(trn_td), 74'(0));
        chk({tag, "_done"}, 74'(wrbck_done), 74'(0));
    endtask

    initial begin
        int r0, d0, s0, viol;
        logic [63:0] p;

        host_addr = 64'h0000_0000_1234_5678;
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        repeat (3) tick();
        chk("no_req_ptr_eq_last", 74'(req_rise), 74'(0));

        // 32-bit address, literal pins of the three beats
        s0 = src_low_cnt;
        push_tlp(host_addr, 64'h0102_0304_0506_0708);
        hw_ptr = 64'h0102_0304_0506_0708;
        wait_done(1);
        chk("a32_beat0", cap[0], mk_beat(64'h4000_0002_0100_00FF, 8'h00, 1'b0, 1'b1));
        chk("a32_beat1", cap[1], mk_beat(64'h1234_5678_0807_0605, 8'h00, 1'b1, 1'b1));
        chk("a32_beat2", cap[2], mk_beat(64'h0403_0201_0000_0000, 8'h0F, 1'b1, 1'b0));
        chk("a32_cycles", 74'(src_low_cnt - s0), 74'(3));

        // 64-bit address
        host_addr = 64'h0000_0001_0000_1000;
        push_tlp(host_addr, 64'hAABB_CCDD_1122_3344);
        hw_ptr = 64'hAABB_CCDD_1122_3344;
        wait_done(1);
        chk("a64_beat0", cap[0], mk_beat(64'h6000_0002_0100_00FF, 8'h00, 1'b0, 1'b1));
        chk("a64_beat1", cap[1], mk_beat(64'h0000_0001_0000_1000, 8'h00, 1'b1, 1'b1));
        chk("a64_beat2", cap[2], mk_beat(64'h4433_2211_DDCC_BBAA, 8'h00, 1'b1, 1'b0));

        // dst_rdy stall for 3 cycles on beat1
        host_addr = 64'h0000_0000_8000_0040;
        s0 = src_low_cnt;
        d0 = done_cnt;
        push_tlp(host_addr, 64'h1111_2222_3333_4444);
        hw_ptr = 64'h1111_2222_3333_4444;
        wait_beat0();
        tick();
        trn_tdst_rdy_n = 1'b1;
        repeat (3) tick();
        trn_tdst_rdy_n = 1'b0;
        wait_done(1);
        repeat (3) tick();
        chk("stall_cycles", 74'(src_low_cnt - s0), 74'(6));
        chk("stall_done_cnt", 74'(done_cnt - d0), 74'(1));

        // five pointer updates during one TLP coalesce into one follow-up
        r0 = req_rise;
        p = 64'h5555_0000_0000_0100;
        trn_tdst_rdy_n = 1'b1;
        push_tlp(host_addr, p);
        hw_ptr = p;
        wait_beat0();
        for (int i = 1; i <= 5; i++) begin
            hw_ptr = p + 64'(i);
            tick();
        end
        trn_tdst_rdy_n = 1'b0;
        push_tlp(host_addr, p + 64'd5);
        wait_done(2);
        repeat (10) tick();
        chk("coalesce_tlps", 74'(req_rise - r0), 74'(2));

        // pointer returns to the in-flight value before IDLE: no follow-up
        r0 = req_rise;
        p = 64'h6666_7777_8888_9999;
        trn_tdst_rdy_n = 1'b1;
        push_tlp(host_addr, p);
        hw_ptr = p;
        wait_beat0();
        hw_ptr = 64'hDEAD;
        tick();
        hw_ptr = p;
        trn_tdst_rdy_n = 1'b0;
        wait_done(1);
        repeat (10) tick();
        chk("back_to_last_tlps", 74'(req_rise - r0), 74'(1));

        // posted buffer unavailable: no sof
        trn_tbuf_av = 4'b1101;
        p = 64'h0000_0000_ABCD_0001;
        push_tlp(host_addr, p);
        hw_ptr = p;
        viol = 0;
        repeat (10) begin
            tick();
            if (!trn_tsrc_rdy_n) viol++;
        end
        chk("tbuf_no_sof", 74'(viol), 74'(0));
        chk("tbuf_req_held", 74'(tx_req), 74'(1));
        trn_tbuf_av = 4'hF;
        wait_done(1);

        // writeback disabled: no request
        r0 = req_rise;
        wrbck_en = 1'b0;
        p = 64'h0000_0000_ABCD_0002;
        hw_ptr = p;
        repeat (20) tick();
        chk("disabled_no_req", 74'(req_rise - r0), 74'(0));
        push_tlp(host_addr, p);
        wrbck_en = 1'b1;
        wait_done(1);

        // reset while beat1 is on the bus
        p = 64'h0000_0000_ABCD_0003;
        push_tlp(host_addr, p);
        hw_ptr = p;
        wait_beat0();
        tick();
        trn_tdst_rdy_n = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1 chk_reset("midtlp_rst");
        exp_q.delete();
        tick();
        tick();
        trn_tdst_rdy_n = 1'b0;
        push_tlp(host_addr, p);
        rst_n = 1'b1;
        wait_done(1);

`ifdef HW_WRBCK_HOLDOFF_EN
        r0 = req_rise;
        repeat (HOLD) tick();
        sb_off = 1'b1;
        hold_chk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            hw_ptr = 64'h100 + 64'(i);
            tick();
            tick();
        end
        repeat (80) tick();
        sb_off = 1'b0;
        hold_chk = 1'b0;
        chk("holdoff_tlps", 74'(req_rise - r0 >= 3), 74'(1));
        chk("holdoff_final_d0", 74'(cap[1][41:10]), 74'(bsw(32'h127)));
`endif

        repeat (5) tick();
        chk("exp_q_empty", 74'(exp_q.size()), 74'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
